// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory copy engine.
package mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_DRAIN,
    ST_WR,
    ST_DONE
  } copy_state_t;

  localparam logic MODE_READ  = 1'b1;
  localparam logic MODE_WRITE = 1'b0;

  localparam int MEM_ADDR_W = 5;
  localparam int MEM_WORDS  = 32;

endpackage

// File: rtl/copy_buf.sv
// Staging buffer: synchronous write from the read-capture pipe, combinational read for the write phase.
module copy_buf
  import mem_pkg::*;
#(
  parameter int DEPTH = MEM_WORDS,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] buf_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      buf_q[waddr] <= wdata;
    end
  end

  assign rdata = buf_q[raddr];

endmodule

// File: rtl/mem_copy_engine.sv
// Memory-port bus master: reads len words from src into a local buffer, then writes them to dst.
module mem_copy_engine
  import mem_pkg::*;
#(
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DEPTH    = MEM_WORDS,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [5:0]        len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              m_mode,
  output logic              m_w_en,
  output logic [31:0]       m_addr,
  output logic [31:0]       m_wdata,
  input  logic [31:0]       m_rdata
);

  localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0] MAX_LEN = 7'(DEPTH);

  copy_state_t       state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [ADDR_W-1:0] addr;
  logic [5:0]        len_q, len_d, cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              issue;
  logic              last;
  logic [IDX_W-1:0]  cnt_idx;
  logic [IDX_W-1:0]  last_idx;
  logic [31:0]       buf_rdata;

  logic [READ_LAT-1:0] pvld_q, pvld_d;
  logic [IDX_W-1:0]    pidx_q [READ_LAT];
  logic [IDX_W-1:0]    pidx_d [READ_LAT];

  assign last     = (cnt_q == len_q - 6'd1);
  assign cnt_idx  = IDX_W'(cnt_q);
  assign last_idx = IDX_W'(len_q - 6'd1);
  assign err      = err_q;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    issue   = 1'b0;
    addr    = '0;
    busy    = 1'b1;
    done    = 1'b0;
    m_mode  = MODE_READ;
    m_w_en  = 1'b0;
    m_wdata = '0;
    unique case (state_q)
      ST_IDLE: begin
        busy  = 1'b0;
        cnt_d = '0;
        if (start) begin
          src_d = src;
          dst_d = dst;
          len_d = len;
          if ({1'b0, len} > MAX_LEN) begin
            err_d = 1'b1;
          end else if (len == 6'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        issue = 1'b1;
        addr  = src_q + ADDR_W'(cnt_q);
        if (last) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_DRAIN: begin
        // Leave only once the final read's capture lands in the buffer this cycle.
        if (pvld_q[READ_LAT-1] && (pidx_q[READ_LAT-1] == last_idx)) begin
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        m_mode  = MODE_WRITE;
        m_w_en  = 1'b1;
        addr    = dst_q + ADDR_W'(cnt_q);
        m_wdata = buf_rdata;
        if (last) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    m_addr = {{(32 - ADDR_W){1'b0}}, addr};
  end

  always_comb begin
    pvld_d    = '0;
    pidx_d    = '{default: '0};
    pvld_d[0] = issue;
    pidx_d[0] = cnt_idx;
    for (int unsigned i = 1; i < READ_LAT; i++) begin
      pvld_d[i] = pvld_q[i-1];
      pidx_d[i] = pidx_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      pvld_q  <= '0;
      pidx_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pvld_q  <= pvld_d;
      pidx_q  <= pidx_d;
    end
  end

  copy_buf #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_buf (
    .clk  (clk),
    .we   (pvld_q[READ_LAT-1]),
    .waddr(pidx_q[READ_LAT-1]),
    .wdata(m_rdata),
    .raddr(cnt_idx),
    .rdata(buf_rdata)
  );

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: three instances (READ_LAT 1..3) in lockstep, each with its own memory model.
module tb_mem_copy_engine;

  localparam int NI   = 3;
  localparam int MAXC = 100;

  logic        clk;
  logic        start;
  logic [4:0]  src, dst;
  logic [5:0]  len;
  logic        rst_v   [NI];
  logic        busy    [NI];
  logic        done    [NI];
  logic        err     [NI];
  logic        m_mode  [NI];
  logic        m_w_en  [NI];
  logic [31:0] m_addr  [NI];
  logic [31:0] m_wdata [NI];
  logic [31:0] m_rdata [NI];

  logic [31:0] mem     [NI][32];
  logic [31:0] rpipe   [NI][4];
  logic [31:0] pre     [NI][32];
  logic [31:0] exp_mem [NI][32];

  logic        obs_busy  [NI][MAXC];
  logic        obs_done  [NI][MAXC];
  logic        obs_mode  [NI][MAXC];
  logic        obs_wen   [NI][MAXC];
  logic [31:0] obs_addr  [NI][MAXC];
  logic [31:0] obs_wdata [NI][MAXC];

  int done_cyc[NI], done_cyc2[NI], done_cnt[NI], err_cyc[NI], err_cnt[NI];
  int busy_first[NI], busy_last[NI], busy_cnt[NI], wen_cnt[NI];

  int   tests, fails;
  bit   mon_en;
  logic done_prev[NI], err_prev[NI];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_copy_engine #(
      .ADDR_W  (5),
      .DEPTH   (32),
      .READ_LAT(g + 1)
    ) u_dut (
      .clk    (clk),
      .rst    (rst_v[g]),
      .start  (start),
      .src    (src),
      .dst    (dst),
      .len    (len),
      .busy   (busy[g]),
      .done   (done[g]),
      .err    (err[g]),
      .m_mode (m_mode[g]),
      .m_w_en (m_w_en[g]),
      .m_addr (m_addr[g]),
      .m_wdata(m_wdata[g]),
      .m_rdata(m_rdata[g])
    );
    assign m_rdata[g] = rpipe[g][g];
  end

  // Single-port memory with registered read data, READ_LAT cycles after the address.
  always @(posedge clk) begin
    for (int j = 0; j < NI; j++) begin
      if (m_w_en[j] === 1'b1) mem[j][m_addr[j][4:0]] <= m_wdata[j];
      rpipe[j][0] <= mem[j][m_addr[j][4:0]];
      for (int k = 1; k < 4; k++) rpipe[j][k] <= rpipe[j][k-1];
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      for (int j = 0; j < NI; j++) begin
        tests++;
        if (m_w_en[j] === 1'b1 && m_mode[j] !== 1'b0) begin
          fails++;
          $display("FAIL proto_wen_mode rl%0d: m_w_en=%b m_mode=%b required m_mode=0", j + 1, m_w_en[j], m_mode[j]);
        end
        tests++;
        if (done[j] === 1'b1 && done_prev[j] === 1'b1) begin
          fails++;
          $display("FAIL proto_done_pulse rl%0d: done high two cycles, required single pulse", j + 1);
        end
        tests++;
        if (err[j] === 1'b1 && err_prev[j] === 1'b1) begin
          fails++;
          $display("FAIL proto_err_pulse rl%0d: err high two cycles, required single pulse", j + 1);
        end
        done_prev[j] = done[j];
        err_prev[j]  = err[j];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic preload(input int kind);
    logic [31:0] v;
    for (int a = 0; a < 32; a++) begin
      if (kind == 0)      v = 32'h100 + 32'(a);
      else if (kind == 1) v = 32'(a);
      else                v = $urandom;
      for (int j = 0; j < NI; j++) mem[j][a] <= v;
    end
  endtask

  // Reference: memmove from the pre-command snapshot, first nw words only.
  task automatic model_copy(input int s, input int d, input int nw);
    for (int j = 0; j < NI; j++) begin
      for (int a = 0; a < 32; a++) exp_mem[j][a] = pre[j][a];
      for (int k = 0; k < nw; k++) exp_mem[j][(d + k) % 32] = pre[j][(s + k) % 32];
    end
  endtask

  // mode 0: plain command; 1: extra junk start pulse in cycle 3; 2: start held high.
  task automatic run_copy(input int s, input int d, input int l, input int mode, input int rst_wr);
    int w;
    @(posedge clk); #1;
    for (int j = 0; j < NI; j++) begin
      for (int a = 0; a < 32; a++) pre[j][a] = mem[j][a];
      done_cyc[j] = -1; done_cyc2[j] = -1; done_cnt[j] = 0; err_cyc[j] = -1; err_cnt[j] = 0;
      busy_first[j] = -1; busy_last[j] = -1; busy_cnt[j] = 0; wen_cnt[j] = 0;
    end
    start = 1'b1; src = s[4:0]; dst = d[4:0]; len = l[5:0];
    @(posedge clk); #1;
    if (mode != 2) begin
      start = 1'b0; src = 5'($urandom); dst = 5'($urandom); len = 6'($urandom_range(1, 32));
    end
    for (int c = 1; c <= 2 * l + 14 && c < MAXC; c++) begin
      for (int j = 0; j < NI; j++) begin
        obs_busy[j][c] = busy[j];   obs_done[j][c] = done[j];
        obs_mode[j][c] = m_mode[j]; obs_wen[j][c]  = m_w_en[j];
        obs_addr[j][c] = m_addr[j]; obs_wdata[j][c] = m_wdata[j];
        if (done[j] === 1'b1) begin
          done_cnt[j]++;
          if (done_cyc[j] < 0) done_cyc[j] = c;
          else if (done_cyc2[j] < 0) done_cyc2[j] = c;
        end
        if (err[j] === 1'b1) begin
          err_cnt[j]++;
          if (err_cyc[j] < 0) err_cyc[j] = c;
        end
        if (busy[j] === 1'b1) begin
          busy_cnt[j]++;
          if (busy_first[j] < 0) busy_first[j] = c;
          busy_last[j] = c;
        end
        if (m_w_en[j] === 1'b1) wen_cnt[j]++;
        rst_v[j] = (rst_wr >= 0) && (c == l + j + 2 + rst_wr);
      end
      if (mode == 1) start = (c == 3);
      @(posedge clk); #1;
    end
    start = 1'b0;
    for (int j = 0; j < NI; j++) rst_v[j] = 1'b0;
    w = 0;
    while (w < 200 && (busy[0] !== 1'b0 || busy[1] !== 1'b0 || busy[2] !== 1'b0)) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 200) begin
      tests++; fails++;
      $display("FAIL drain_timeout: busy still high after %0d cycles, required idle", w);
    end
  endtask

  task automatic test_reset();
    for (int j = 0; j < NI; j++) rst_v[j] = 1'b1;
    start = 1'b0; src = '0; dst = '0; len = '0;
    preload(2);
    repeat (3) @(posedge clk);
    #1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int j = 0; j < NI; j++) begin
        tests++;
        if (busy[j] !== 1'b0 || done[j] !== 1'b0 || err[j] !== 1'b0 || m_mode[j] !== 1'b1 ||
            m_w_en[j] !== 1'b0 || m_addr[j] !== 32'h0 || m_wdata[j] !== 32'h0) begin
          fails++;
          $display("FAIL reset_values rl%0d pass%0d: busy=%b done=%b err=%b mode=%b wen=%b addr=%h wdata=%h required 0 0 0 1 0 0 0",
                   j + 1, pass, busy[j], done[j], err[j], m_mode[j], m_w_en[j], m_addr[j], m_wdata[j]);
        end
      end
      for (int j = 0; j < NI; j++) rst_v[j] = 1'b0;
      @(posedge clk); #1;
    end
    mon_en = 1'b1;
  endtask

  task automatic test_copies();
    int ts[$], td[$], tl[$], tp[$];
    ts = '{2, 0, 30, 7, 9};
    td = '{20, 1, 0, 12, 9};
    tl = '{4, 8, 4, 32, 5};
    tp = '{0, 1, 2, 2, 2};
    for (int i = 0; i < 6; i++) begin
      ts.push_back($urandom_range(0, 31)); td.push_back($urandom_range(0, 31));
      tl.push_back($urandom_range(1, 32)); tp.push_back(2);
    end
    foreach (ts[n]) begin
      int l;
      l = tl[n];
      preload(tp[n]);
      run_copy(ts[n], td[n], l, 0, -1);
      model_copy(ts[n], td[n], l);
      for (int j = 0; j < NI; j++) begin
        int ed;
        ed = 2 * l + (j + 1) + 1;
        tests++;
        if (done_cyc[j] !== ed || done_cnt[j] !== 1) begin
          fails++;
          $display("FAIL copy%0d_done rl%0d: done cycle %0d count %0d, required cycle %0d count 1", n, j + 1, done_cyc[j], done_cnt[j], ed);
        end
        tests++;
        if (busy_first[j] !== 1 || busy_last[j] !== ed || busy_cnt[j] !== ed || err_cnt[j] !== 0) begin
          fails++;
          $display("FAIL copy%0d_busy rl%0d: busy %0d..%0d (%0d cycles) err %0d, required 1..%0d err 0",
                   n, j + 1, busy_first[j], busy_last[j], busy_cnt[j], err_cnt[j], ed);
        end
        tests++;
        if (wen_cnt[j] !== l) begin
          fails++;
          $display("FAIL copy%0d_wen_count rl%0d: %0d write cycles, required %0d", n, j + 1, wen_cnt[j], l);
        end
        for (int k = 0; k < l; k++) begin
          tests++;
          if (obs_mode[j][1 + k] !== 1'b1 || obs_addr[j][1 + k] !== 32'((ts[n] + k) % 32)) begin
            fails++;
            $display("FAIL copy%0d_rd_addr rl%0d k%0d: mode=%b addr=%0d, required mode=1 addr=%0d",
                     n, j + 1, k, obs_mode[j][1 + k], obs_addr[j][1 + k], (ts[n] + k) % 32);
          end
        end
        for (int k = 0; k < l; k++) begin
          int c;
          c = l + (j + 1) + 1 + k;
          tests++;
          if (obs_wen[j][c] !== 1'b1 || obs_addr[j][c] !== 32'((td[n] + k) % 32) ||
              obs_wdata[j][c] !== pre[j][(ts[n] + k) % 32]) begin
            fails++;
            $display("FAIL copy%0d_wr rl%0d k%0d: wen=%b addr=%0d data=%h, required wen=1 addr=%0d data=%h",
                     n, j + 1, k, obs_wen[j][c], obs_addr[j][c], obs_wdata[j][c], (td[n] + k) % 32, pre[j][(ts[n] + k) % 32]);
          end
        end
        for (int a = 0; a < 32; a++) begin
          tests++;
          if (mem[j][a] !== exp_mem[j][a]) begin
            fails++;
            $display("FAIL copy%0d_mem rl%0d [%0d]: got %h required %h", n, j + 1, a, mem[j][a], exp_mem[j][a]);
          end
        end
      end
    end
  endtask

  task automatic test_len_zero();
    preload(2);
    run_copy(4, 10, 0, 0, -1);
    model_copy(4, 10, 0);
    for (int j = 0; j < NI; j++) begin
      tests++;
      if (done_cyc[j] !== 1 || done_cnt[j] !== 1 || busy_first[j] !== 1 || busy_cnt[j] !== 1 ||
          wen_cnt[j] !== 0 || err_cnt[j] !== 0) begin
        fails++;
        $display("FAIL len0 rl%0d: done@%0d x%0d busy@%0d x%0d wen %0d err %0d, required done@1 x1 busy@1 x1 wen 0 err 0",
                 j + 1, done_cyc[j], done_cnt[j], busy_first[j], busy_cnt[j], wen_cnt[j], err_cnt[j]);
      end
      for (int a = 0; a < 32; a++) begin
        tests++;
        if (mem[j][a] !== exp_mem[j][a]) begin
          fails++;
          $display("FAIL len0_mem rl%0d [%0d]: got %h required %h", j + 1, a, mem[j][a], exp_mem[j][a]);
        end
      end
    end
  endtask

  task automatic test_len_err();
    int lens[2];
    lens[0] = 33;
    lens[1] = $urandom_range(34, 63);
    for (int n = 0; n < 2; n++) begin
      preload(2);
      run_copy($urandom_range(0, 31), $urandom_range(0, 31), lens[n], 0, -1);
      for (int j = 0; j < NI; j++) begin
        tests++;
        if (err_cyc[j] !== 1 || err_cnt[j] !== 1 || busy_cnt[j] !== 0 || done_cnt[j] !== 0 || wen_cnt[j] !== 0) begin
          fails++;
          $display("FAIL len_err len%0d rl%0d: err@%0d x%0d busy x%0d done x%0d wen %0d, required err@1 x1 and no activity",
                   lens[n], j + 1, err_cyc[j], err_cnt[j], busy_cnt[j], done_cnt[j], wen_cnt[j]);
        end
        for (int a = 0; a < 32; a++) begin
          tests++;
          if (mem[j][a] !== pre[j][a]) begin
            fails++;
            $display("FAIL len_err_mem rl%0d [%0d]: got %h required %h", j + 1, a, mem[j][a], pre[j][a]);
          end
        end
      end
    end
  endtask

  task automatic test_ignore_start();
    preload(0);
    run_copy(2, 20, 4, 1, -1);
    model_copy(2, 20, 4);
    for (int j = 0; j < NI; j++) begin
      int ed;
      ed = 2 * 4 + (j + 1) + 1;
      tests++;
      if (done_cyc[j] !== ed || done_cnt[j] !== 1 || busy_cnt[j] !== ed || wen_cnt[j] !== 4) begin
        fails++;
        $display("FAIL ignore_start rl%0d: done@%0d x%0d busy x%0d wen %0d, required done@%0d x1 busy x%0d wen 4",
                 j + 1, done_cyc[j], done_cnt[j], busy_cnt[j], wen_cnt[j], ed, ed);
      end
      for (int a = 0; a < 32; a++) begin
        tests++;
        if (mem[j][a] !== exp_mem[j][a]) begin
          fails++;
          $display("FAIL ignore_start_mem rl%0d [%0d]: got %h required %h", j + 1, a, mem[j][a], exp_mem[j][a]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_write();
    preload(2);
    run_copy(4, 16, 6, 0, 1);
    model_copy(4, 16, 2);
    for (int j = 0; j < NI; j++) begin
      int rc;
      rc = 6 + (j + 1) + 3;
      tests++;
      if (obs_busy[j][rc] !== 1'b0 || obs_done[j][rc] !== 1'b0 || obs_mode[j][rc] !== 1'b1 ||
          obs_wen[j][rc] !== 1'b0 || obs_addr[j][rc] !== 32'h0 || obs_wdata[j][rc] !== 32'h0) begin
        fails++;
        $display("FAIL rst_mid_state rl%0d: busy=%b done=%b mode=%b wen=%b addr=%h wdata=%h, required 0 0 1 0 0 0",
                 j + 1, obs_busy[j][rc], obs_done[j][rc], obs_mode[j][rc], obs_wen[j][rc], obs_addr[j][rc], obs_wdata[j][rc]);
      end
      tests++;
      if (wen_cnt[j] !== 2 || done_cnt[j] !== 0) begin
        fails++;
        $display("FAIL rst_mid_counts rl%0d: wen %0d done %0d, required wen 2 done 0", j + 1, wen_cnt[j], done_cnt[j]);
      end
      for (int a = 0; a < 32; a++) begin
        tests++;
        if (mem[j][a] !== exp_mem[j][a]) begin
          fails++;
          $display("FAIL rst_mid_mem rl%0d [%0d]: got %h required %h", j + 1, a, mem[j][a], exp_mem[j][a]);
        end
      end
    end
    run_copy(10, 25, 6, 0, -1);
    model_copy(10, 25, 6);
    for (int j = 0; j < NI; j++) begin
      tests++;
      if (done_cyc[j] !== 12 + (j + 1) + 1 || done_cnt[j] !== 1) begin
        fails++;
        $display("FAIL rst_then_copy_done rl%0d: done@%0d x%0d, required done@%0d x1", j + 1, done_cyc[j], done_cnt[j], 12 + j + 2);
      end
      for (int a = 0; a < 32; a++) begin
        tests++;
        if (mem[j][a] !== exp_mem[j][a]) begin
          fails++;
          $display("FAIL rst_then_copy_mem rl%0d [%0d]: got %h required %h", j + 1, a, mem[j][a], exp_mem[j][a]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    preload(2);
    run_copy(3, 9, 1, 2, -1);
    model_copy(3, 9, 1);
    for (int j = 0; j < NI; j++) begin
      int r;
      r = j + 1;
      tests++;
      if (done_cyc[j] !== r + 3 || obs_busy[j][r + 4] !== 1'b0 || obs_busy[j][r + 5] !== 1'b1 || done_cyc2[j] !== 2 * r + 7) begin
        fails++;
        $display("FAIL back_to_back rl%0d: done@%0d idle-gap busy=%b next busy=%b done2@%0d, required done@%0d 0 1 done2@%0d",
                 r, done_cyc[j], obs_busy[j][r + 4], obs_busy[j][r + 5], done_cyc2[j], r + 3, 2 * r + 7);
      end
      for (int a = 0; a < 32; a++) begin
        tests++;
        if (mem[j][a] !== exp_mem[j][a]) begin
          fails++;
          $display("FAIL back_to_back_mem rl%0d [%0d]: got %h required %h", r, a, mem[j][a], exp_mem[j][a]);
        end
      end
    end
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    mon_en = 1'b0;
    test_reset();
    test_copies();
    test_len_zero();
    test_len_err();
    test_ignore_start();
    test_reset_mid_write();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
